// File: rtl/fpl_config_loader.sv
// Streams a byte-wide configuration image into the per-function registers on a
// simple write-only bus master, then compares a trailing XOR checksum byte.
module fpl_config_loader #(
  parameter int NUM_FUNCS     = 8,
  parameter int REGS_PER_FUNC = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted
);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, CHECK, FIN} state_t;

  localparam logic [3:0] LAST_FUNC = 4'(NUM_FUNCS - 1);
  localparam logic [2:0] LAST_REG  = 3'(REGS_PER_FUNC - 1);

  state_t      r_state;
  logic [3:0]  r_func_idx;
  logic [2:0]  r_reg_idx;
  logic [7:0]  r_csum;
  logic        r_rdy;
  logic        r_abort_pend;
  logic        r_m_valid;
  logic [15:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wstrb;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_aborted;

  logic        w_take;
  logic        w_last_reg;
  logic        w_last_write;

  // An abort in the same cycle must block the byte handshake, so it gates ready directly.
  assign s_ready      = r_rdy & ~abort;
  assign w_take       = s_valid & s_ready;
  assign w_last_reg   = (r_reg_idx == LAST_REG);
  assign w_last_write = w_last_reg && (r_func_idx == LAST_FUNC);

  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;
  assign m_valid = r_m_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign aborted = r_aborted;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_func_idx   <= '0;
      r_reg_idx    <= '0;
      r_csum       <= '0;
      r_rdy        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= FETCH;
            r_func_idx   <= '0;
            r_reg_idx    <= '0;
            r_csum       <= '0;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_rdy        <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        FETCH: begin
          if (abort) begin
            r_state   <= FIN;
            r_rdy     <= 1'b0;
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
          end else if (w_take) begin
            r_state   <= WRITE;
            r_rdy     <= 1'b0;
            r_csum    <= r_csum ^ s_data;
            r_m_valid <= 1'b1;
            r_m_addr  <= {4'h0, r_func_idx, 5'h00, r_reg_idx};
            r_m_wdata <= {24'h0, s_data};
            r_m_wstrb <= 4'b0001;
          end
        end
        WRITE: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            if (w_last_reg) begin
              r_reg_idx  <= '0;
              r_func_idx <= r_func_idx + 4'd1;
            end else begin
              r_reg_idx <= r_reg_idx + 3'd1;
            end
            if (abort || r_abort_pend) begin
              r_state   <= FIN;
              r_aborted <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_state <= w_last_write ? CHECK : FETCH;
              r_rdy   <= 1'b1;
            end
          end else if (abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            r_state   <= FIN;
            r_rdy     <= 1'b0;
            r_aborted <= 1'b1;
            r_done    <= 1'b1;
          end else if (w_take) begin
            r_state <= FIN;
            r_rdy   <= 1'b0;
            r_err   <= (s_data != r_csum);
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpl_config_loader.sv
// Bench for fpl_config_loader: a default-sized and a two-function instance driven by a
// byte source and a bus-slave model, with writes compared against an address/data model.
module tb_fpl_config_loader;
  typedef struct {
    int         nf;
    logic [7:0] flip;
    bit         rnd_timing;
    bit         rnd_data;
    int         abort_wr;
    int         reset_wr;
    bit         exp_err;
    bit         exp_ab;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic clk = 1'b0;
  logic resetn;
  logic start_a, start_b, abort;
  logic [7:0] s_data;
  logic s_valid, m_ready;

  logic        s_ready_o [2];
  logic [15:0] m_addr_o  [2];
  logic [31:0] m_wdata_o [2];
  logic [3:0]  m_wstrb_o [2];
  logic        m_valid_o [2];
  logic        busy_o    [2];
  logic        done_o    [2];
  logic        err_o     [2];
  logic        aborted_o [2];

  bit sel;
  logic        cur_s_ready, cur_m_valid, cur_busy, cur_done, cur_err, cur_aborted;
  logic [15:0] cur_m_addr;
  logic [31:0] cur_m_wdata;
  logic [3:0]  cur_m_wstrb;

  assign cur_s_ready = s_ready_o[sel];
  assign cur_m_valid = m_valid_o[sel];
  assign cur_busy    = busy_o[sel];
  assign cur_done    = done_o[sel];
  assign cur_err     = err_o[sel];
  assign cur_aborted = aborted_o[sel];
  assign cur_m_addr  = m_addr_o[sel];
  assign cur_m_wdata = m_wdata_o[sel];
  assign cur_m_wstrb = m_wstrb_o[sel];

  fpl_config_loader #(.NUM_FUNCS(8), .REGS_PER_FUNC(5)) u_dut (
    .clk(clk), .resetn(resetn), .start(start_a), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[0]),
    .m_addr(m_addr_o[0]), .m_wdata(m_wdata_o[0]), .m_wstrb(m_wstrb_o[0]),
    .m_valid(m_valid_o[0]), .m_ready(m_ready),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .aborted(aborted_o[0])
  );

  fpl_config_loader #(.NUM_FUNCS(2), .REGS_PER_FUNC(5)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start_b), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[1]),
    .m_addr(m_addr_o[1]), .m_wdata(m_wdata_o[1]), .m_wstrb(m_wstrb_o[1]),
    .m_valid(m_valid_o[1]), .m_ready(m_ready),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .aborted(aborted_o[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] src_q[$];
  wr_t wr_q[$];
  int done_cnt = 0;
  int bytes_consumed = 0;
  bit rnd_timing = 0;
  int dly = 1;
  bit exp_err_hold [2];
  bit exp_ab_hold  [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Byte source, bus slave and protocol monitor: observe at negedge, drive 1ns after posedge.
  initial begin : env
    bit took_byte, took_wr, prev_wait, prev_took;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    int cnt;
    wr_t w;
    s_valid = 0; s_data = 0; m_ready = 0;
    cnt = 0; prev_wait = 0; prev_took = 0; prev_addr = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      took_byte = 0;
      took_wr = 0;
      if (resetn) begin
        took_byte = s_valid && cur_s_ready;
        took_wr   = cur_m_valid && m_ready;
        if (prev_wait) begin
          checks++;
          if (!cur_m_valid || cur_m_addr !== prev_addr || cur_m_wdata !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: got v=%0b a=%0h d=%0h expected v=1 a=%0h d=%0h",
                     cur_m_valid, cur_m_addr, cur_m_wdata, prev_addr, prev_data);
          end
        end
        if (prev_took) begin
          checks++;
          if (cur_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_back_to_back: got m_valid=%0b expected 0", cur_m_valid);
          end
        end
        if (cur_s_ready && cur_m_valid) begin
          checks++;
          errors++;
          $display("FAIL ready_valid_excl: got s_ready=1 m_valid=1 expected not both");
        end
        if (cur_done) done_cnt++;
        if (took_wr) begin
          w.a = cur_m_addr; w.d = cur_m_wdata; w.s = cur_m_wstrb;
          wr_q.push_back(w);
        end
        prev_wait = cur_m_valid && !m_ready;
        prev_addr = cur_m_addr;
        prev_data = cur_m_wdata;
        prev_took = took_wr;
      end else begin
        prev_wait = 0;
        prev_took = 0;
      end
      @(posedge clk);
      #1;
      if (took_byte && src_q.size() > 0) begin
        void'(src_q.pop_front());
        bytes_consumed++;
      end
      if (src_q.size() > 0 && (!rnd_timing || $urandom_range(0, 2) != 0)) begin
        s_valid = 1; s_data = src_q[0];
      end else begin
        s_valid = 0; s_data = 8'h00;
      end
      if (m_ready || !cur_m_valid) begin
        m_ready = 0; cnt = 0;
      end else if (cnt >= dly) begin
        m_ready = 1; cnt = 0;
        dly = rnd_timing ? int'($urandom_range(0, 5)) : 1;
      end else begin
        cnt++;
      end
    end
  end

  task automatic do_load(input vec_t v, input int idx);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    int n, exp_wr, exp_bytes;
    bit finished, was_reset, abort_sent;
    n = v.nf * 5;
    cs = 8'h00;
    bytes.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = v.rnd_data ? 8'($urandom) : 8'(i);
      bytes.push_back(b);
      cs ^= b;
    end
    sel = (v.nf == 2);
    rnd_timing = v.rnd_timing;
    dly = v.rnd_timing ? int'($urandom_range(0, 5)) : 1;
    wr_q.delete();
    done_cnt = 0;
    bytes_consumed = 0;
    chk($sformatf("v%0d_err_held", idx), cur_err, exp_err_hold[sel]);
    chk($sformatf("v%0d_aborted_held", idx), cur_aborted, exp_ab_hold[sel]);
    src_q = bytes;
    src_q.push_back(cs ^ v.flip);
    if (sel) start_b = 1; else start_a = 1;
    @(posedge clk); #2;
    start_a = 0; start_b = 0;
    chk($sformatf("v%0d_busy_after_start", idx), cur_busy, 1);
    chk($sformatf("v%0d_flags_cleared", idx), {cur_err, cur_aborted}, 0);
    finished = 0; was_reset = 0; abort_sent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      abort = 0;
      if (v.abort_wr > 0 && !abort_sent && wr_q.size() == v.abort_wr - 1 && cur_m_valid && !m_ready) begin
        abort = 1;
        abort_sent = 1;
      end
      if (v.reset_wr > 0 && wr_q.size() == v.reset_wr) begin
        #1 resetn = 0;
        #1;
        chk($sformatf("v%0d_async_reset_outs", idx),
            {cur_s_ready, cur_m_valid, cur_busy, cur_done, cur_err, cur_aborted,
             cur_m_addr, cur_m_wdata, cur_m_wstrb}, 0);
        src_q.delete();
        repeat (2) @(posedge clk);
        #2 resetn = 1;
        was_reset = 1;
        break;
      end
      if (done_cnt > 0 && !cur_busy) begin
        finished = 1;
        break;
      end
      @(posedge clk); #2;
    end
    abort = 0;
    if (!finished && !was_reset) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got busy=%0b done_cnt=%0d expected load end", idx, cur_busy, done_cnt);
    end
    exp_wr = (v.abort_wr > 0) ? v.abort_wr : (v.reset_wr > 0) ? v.reset_wr : n;
    exp_bytes = (v.abort_wr > 0) ? v.abort_wr : n + 1;
    chk($sformatf("v%0d_write_count", idx), wr_q.size(), exp_wr);
    for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
      logic [15:0] ea;
      ea = 16'((i / 5) * 256 + (i % 5));
      chk($sformatf("v%0d_wr%0d_addr_data_strb", idx, i), {wr_q[i].a, wr_q[i].d, wr_q[i].s},
          {ea, 24'h0, bytes[i], 4'b0001});
    end
    if (was_reset) begin
      chk($sformatf("v%0d_no_done_on_reset", idx), done_cnt, 0);
      exp_err_hold[0] = 0; exp_ab_hold[0] = 0;
      exp_err_hold[1] = 0; exp_ab_hold[1] = 0;
    end else begin
      chk($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
      chk($sformatf("v%0d_bytes_consumed", idx), bytes_consumed, exp_bytes);
      chk($sformatf("v%0d_err", idx), cur_err, v.exp_err);
      chk($sformatf("v%0d_aborted", idx), cur_aborted, v.exp_ab);
      exp_err_hold[sel] = v.exp_err;
      exp_ab_hold[sel] = v.exp_ab;
    end
    src_q.delete();
  endtask

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8, 8'h00, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0};
    vecs[1] = '{8, 8'hFF, 1'b0, 1'b0, 0, 0,  1'b1, 1'b0};
    vecs[2] = '{8, 8'h00, 1'b0, 1'b0, 3, 0,  1'b0, 1'b1};
    vecs[3] = '{8, 8'h00, 1'b1, 1'b0, 0, 0,  1'b0, 1'b0};
    vecs[4] = '{8, 8'h00, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0};
    vecs[5] = '{8, 8'h00, 1'b0, 1'b0, 0, 10, 1'b0, 1'b0};
    vecs[6] = '{8, 8'h00, 1'b0, 1'b1, 0, 0,  1'b0, 1'b0};
    vecs[7] = '{2, 8'h00, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0};
    vecs[8] = '{2, 8'h5A, 1'b1, 1'b1, 0, 0,  1'b1, 1'b0};
    exp_err_hold[0] = 0; exp_err_hold[1] = 0;
    exp_ab_hold[0] = 0;  exp_ab_hold[1] = 0;

    resetn = 0; start_a = 0; start_b = 0; abort = 0; sel = 0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_state_dut%0d", i),
          {s_ready_o[i], m_valid_o[i], busy_o[i], done_o[i], err_o[i], aborted_o[i],
           m_addr_o[i], m_wdata_o[i], m_wstrb_o[i]}, 0);
    end

    // Start on the first edge after reset release, with abort also high: start wins.
    @(posedge clk); #2;
    src_q = '{8'h11, 8'h22};
    rnd_timing = 0;
    resetn = 1; start_a = 1; abort = 1;
    @(posedge clk); #2;
    start_a = 0;
    chk("hand_start_beats_abort", {cur_busy, cur_aborted}, 2'b10);
    chk("hand_fetch_abort_blocks_ready", {s_valid, cur_s_ready}, 2'b10);
    @(posedge clk); #2;
    abort = 0;
    chk("hand_fetch_abort_fin", {cur_done, cur_aborted, cur_err}, 3'b110);
    @(posedge clk); #2;
    chk("hand_fetch_abort_idle", {cur_busy, cur_done}, 0);
    chk("hand_fetch_abort_no_bytes", bytes_consumed, 0);
    abort = 1;
    @(posedge clk); #2;
    abort = 0;
    chk("hand_idle_abort_ignored", {cur_busy, cur_aborted}, 2'b01);
    src_q.delete();
    bytes_consumed = 0;
    exp_ab_hold[0] = 1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i], i);
      repeat (3) @(posedge clk);
      #2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
